// File: rtl/ahb_uart_tx.sv
// AHB-Lite slave wrapping a transmit-only UART.
// A small TX FIFO sits between the bus and the shift FSM. A programmable
// baud divisor sets the number of clocks per bit.
module ahb_uart_tx #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] BAUD_RESET = 16'd16
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic        o_tx,
   output logic        o_busy
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t      state;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        tx_reg;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [15:0]   baud_div;

   logic       dp_write;
   logic [1:0] dp_addr;

   logic        accept;
   logic        wr_data;
   logic        wr_status;
   logic        wr_baud;
   logic        fifo_full;
   logic        fifo_empty;
   logic        pop;
   logic        push_ok;
   logic        overflow_set;
   logic [7:0]  head;
   logic [15:0] eff_baud;
   logic [15:0] reload;
   logic        unused_bits;

   assign HREADYOUT = 1'b1;
   assign HRESP     = 1'b0;

   assign accept     = HSEL & HREADY & HTRANS[1];
   assign wr_data    = dp_write & (dp_addr == 2'd0);
   assign wr_status  = dp_write & (dp_addr == 2'd1);
   assign wr_baud    = dp_write & (dp_addr == 2'd2);
   assign fifo_full  = (count == DEPTH_C);
   assign fifo_empty = (count == '0);
   assign head       = mem[rd_ptr];

   // A divisor of zero behaves as one clock per bit.
   assign eff_baud = (baud_div == 16'd0) ? 16'd1 : baud_div;
   assign reload   = eff_baud - 16'd1;

   // The FSM takes a byte when idle, or at the end of STOP for back-to-back frames.
   assign pop = ~fifo_empty &
                ((state == IDLE) | ((state == STOP) & (bit_cnt == 16'd0)));
   // A full FIFO still takes a byte when a slot is freed in the same cycle.
   assign push_ok      = wr_data & (~fifo_full | pop);
   assign overflow_set = wr_data & fifo_full & ~pop;

   assign o_tx   = tx_reg;
   assign o_busy = (state != IDLE) | ~fifo_empty;

   assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:16]};

   // Register the address-phase controls for use in the following data phase.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         dp_write <= 1'b0;
         dp_addr  <= 2'd0;
      end else if (HREADY) begin
         dp_write <= accept & HWRITE;
         if (accept) dp_addr <= HADDR[3:2];
      end
   end

   // Read mux follows the registered data-phase address.
   always_comb begin
      HRDATA = 32'd0;
      case (dp_addr)
         2'd1:    HRDATA[3:0]  = {overflow, fifo_empty, fifo_full, o_busy};
         2'd2:    HRDATA[15:0] = baud_div;
         default: HRDATA = 32'd0;
      endcase
   end

   // FIFO storage is left unreset; pointers and count define what is valid.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr] <= HWDATA[7:0];
   end

   // FIFO pointers, occupancy, sticky overflow and the baud divisor register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         baud_div <= BAUD_RESET;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         if (overflow_set)
            overflow <= 1'b1;
         else if (wr_status & HWDATA[3])
            overflow <= 1'b0;
         if (wr_baud) baud_div <= HWDATA[15:0];
      end
   end

   // Transmit FSM: start bit, eight data bits LSB first, stop bit, each eff_baud clocks.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state   <= IDLE;
         bit_cnt <= 16'd0;
         bit_idx <= 3'd0;
         shreg   <= 8'd0;
         tx_reg  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               tx_reg <= 1'b1;
               if (!fifo_empty) begin
                  shreg   <= head;
                  bit_cnt <= reload;
                  tx_reg  <= 1'b0;
                  state   <= START;
               end
            end
            START: begin
               if (bit_cnt == 16'd0) begin
                  state   <= DATA;
                  bit_cnt <= reload;
                  bit_idx <= 3'd0;
                  tx_reg  <= shreg[0];
                  shreg   <= {1'b0, shreg[7:1]};
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            DATA: begin
               if (bit_cnt == 16'd0) begin
                  bit_cnt <= reload;
                  if (bit_idx == 3'd7) begin
                     state  <= STOP;
                     tx_reg <= 1'b1;
                  end else begin
                     tx_reg  <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            STOP: begin
               if (bit_cnt == 16'd0) begin
                  if (!fifo_empty) begin
                     shreg   <= head;
                     bit_cnt <= reload;
                     tx_reg  <= 1'b0;
                     state   <= START;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            default: begin
               state  <= IDLE;
               tx_reg <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ahb_uart_tx.sv
// Directed testbench for ahb_uart_tx: bus register access, frame timing,
// FIFO back-to-back and overflow behaviour, divisor change and reset abort.
module tb_ahb_uart_tx;

   logic        i_clk;
   logic        i_reset;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   logic        o_tx;
   logic        o_busy;

   int checks = 0;
   int errors = 0;

   ahb_uart_tx #(
      .FIFO_DEPTH(4),
      .BAUD_RESET(16'd16)
   ) dut (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .o_tx      (o_tx),
      .o_busy    (o_busy)
   );

   // 10 ns clock.
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Guard against a hung run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HADDR  = 32'd0;
   endtask

   // Single write; returns one cycle after the data phase, just past the edge.
   task automatic apply_write(input logic [31:0] addr, input logic [31:0] data);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b1;
      HADDR  = addr;
      @(posedge i_clk); #1;
      bus_idle();
      HWDATA = data;
      @(posedge i_clk); #1;
   endtask

   // Pipelined DATA writes on consecutive cycles; byte i sits in bytes[8*i +: 8].
   task automatic apply_data_burst(input logic [47:0] bytes, input int n);
      for (int i = 0; i <= n; i++) begin
         if (i < n) begin
            HSEL   = 1'b1;
            HTRANS = 2'b10;
            HWRITE = 1'b1;
            HADDR  = 32'h0;
         end else begin
            bus_idle();
         end
         if (i > 0) HWDATA = {24'd0, bytes[8*(i-1) +: 8]};
         @(posedge i_clk); #1;
      end
   endtask

   task automatic apply_read(input logic [31:0] addr, output logic [31:0] data);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = 1'b0;
      HADDR  = addr;
      @(posedge i_clk); #1;
      bus_idle();
      @(negedge i_clk);
      data = HRDATA;
      @(posedge i_clk); #1;
   endtask

   // Expect o_tx at a fixed level for n following cycles.
   task automatic check_level(input string tag, input logic level, input int n);
      for (int j = 0; j < n; j++) begin
         @(posedge i_clk);
         @(negedge i_clk);
         check_output(tag, {31'd0, o_tx}, {31'd0, level});
      end
   endtask

   // Expect a whole frame starting at the next cycle.
   task automatic check_frame(input string tag, input logic [7:0] b, input int bd);
      check_level({tag, "_start"}, 1'b0, bd);
      for (int k = 0; k < 8; k++) check_level({tag, "_data"}, b[k], bd);
      check_level({tag, "_stop"}, 1'b1, bd);
   endtask

   initial begin
      logic [31:0] rd;
      int lows;

      bus_idle();
      HSIZE   = 3'b010;
      HWDATA  = 32'd0;
      HREADY  = 1'b1;
      i_reset = 1'b1;

      // Reset state.
      @(negedge i_clk);
      check_output("rst_tx", {31'd0, o_tx}, 32'd1);
      check_output("rst_busy", {31'd0, o_busy}, 32'd0);
      check_output("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check_output("rst_hresp", {31'd0, HRESP}, 32'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      apply_read(32'h4, rd);
      check_output("rst_status", rd, 32'h4);
      apply_read(32'h8, rd);
      check_output("rst_baud", rd, 32'd16);
      apply_read(32'h0, rd);
      check_output("data_read_zero", rd, 32'd0);

      // Single frame 0x55 at four clocks per bit.
      $display("[TB] frame 0x55 at BAUDDIV=4");
      apply_write(32'h8, 32'd4);
      apply_write(32'h0, 32'h55);
      @(negedge i_clk);
      check_output("d1_tx_idle", {31'd0, o_tx}, 32'd1);
      check_output("d1_busy", {31'd0, o_busy}, 32'd1);
      check_frame("f55", 8'h55, 4);
      check_output("f55_busy_last", {31'd0, o_busy}, 32'd1);
      @(posedge i_clk); @(negedge i_clk);
      check_output("f55_busy_done", {31'd0, o_busy}, 32'd0);
      check_output("f55_tx_done", {31'd0, o_tx}, 32'd1);

      // Four back-to-back frames at two clocks per bit.
      $display("[TB] back-to-back frames at BAUDDIV=2");
      apply_write(32'h8, 32'd2);
      fork
         apply_data_burst({16'd0, 8'h00, 8'hFF, 8'h0F, 8'hA5}, 4);
         begin
            @(posedge i_clk); #1;
            @(posedge i_clk); #1;
            check_frame("b2b_a5", 8'hA5, 2);
            check_frame("b2b_0f", 8'h0F, 2);
            check_frame("b2b_ff", 8'hFF, 2);
            check_frame("b2b_00", 8'h00, 2);
         end
      join
      @(posedge i_clk); #1;
      apply_read(32'h4, rd);
      check_output("b2b_status", rd, 32'h4);

      // Overflow: six pushes into a four-entry FIFO while the first frame runs.
      $display("[TB] overflow at BAUDDIV=100");
      apply_write(32'h8, 32'd100);
      apply_data_burst({8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11}, 6);
      apply_read(32'h4, rd);
      check_output("ovf_status", rd, 32'hB);
      apply_write(32'h4, 32'h8);
      apply_read(32'h4, rd);
      check_output("ovf_cleared", rd, 32'h3);
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;

      // Reset in the middle of bit 3 with two bytes still queued.
      $display("[TB] reset abort mid-frame");
      apply_write(32'h8, 32'd4);
      apply_data_burst({24'd0, 8'h33, 8'hCC, 8'hF0}, 3);
      repeat (16) @(posedge i_clk);
      #1;
      check_output("abort_bit3_low", {31'd0, o_tx}, 32'd0);
      i_reset = 1'b1;
      #1;
      check_output("abort_tx_high", {31'd0, o_tx}, 32'd1);
      check_output("abort_busy", {31'd0, o_busy}, 32'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      apply_read(32'h4, rd);
      check_output("abort_status", rd, 32'h4);
      apply_read(32'h8, rd);
      check_output("abort_baud", rd, 32'd16);
      lows = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge i_clk);
         if (o_tx !== 1'b1) lows++;
      end
      check_output("abort_no_frames", lows, 32'd0);

      // Divisor change during DATA: bit 0 keeps 8 clocks, later bits use 3.
      $display("[TB] divisor change mid-frame");
      apply_write(32'h8, 32'd8);
      apply_write(32'h0, 32'h55);
      repeat (10) @(posedge i_clk);
      #1;
      apply_write(32'h8, 32'd3);
      check_level("chg_bit0", 1'b1, 4);
      check_level("chg_bit1", 1'b0, 3);
      check_level("chg_bit2", 1'b1, 3);
      check_level("chg_bit3", 1'b0, 3);
      check_level("chg_bit4", 1'b1, 3);
      check_level("chg_bit5", 1'b0, 3);
      check_level("chg_bit6", 1'b1, 3);
      check_level("chg_bit7", 1'b0, 3);
      check_level("chg_stop", 1'b1, 3);
      @(posedge i_clk); @(negedge i_clk);
      check_output("chg_busy_done", {31'd0, o_busy}, 32'd0);

      // Divisor zero runs at one clock per bit; reserved register reads zero.
      $display("[TB] BAUDDIV=0 and reserved register");
      apply_write(32'h8, 32'd0);
      apply_read(32'h8, rd);
      check_output("baud0_read", rd, 32'd0);
      apply_write(32'h0, 32'hA5);
      check_frame("fast_a5", 8'hA5, 1);
      @(posedge i_clk); @(negedge i_clk);
      check_output("fast_busy_done", {31'd0, o_busy}, 32'd0);
      apply_write(32'hC, 32'hFFFF_FFFF);
      apply_read(32'hC, rd);
      check_output("reserved_read", rd, 32'd0);
      check_output("end_hreadyout", {31'd0, HREADYOUT}, 32'd1);
      check_output("end_hresp", {31'd0, HRESP}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ahb_uart_tx.md
AHB_UART_TX -- requirements
Module: ahb_uart_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-002 Parameter BAUD_RESET, default 16'd16, reset value of BAUDDIV (clocks per bit).
REQ-003 i_clk  in  1  single clock, same as bus HCLK; all state on rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 HSEL  in  1  slave select.
REQ-006 HADDR  in  32  address; only HADDR[3:2] decoded.
REQ-007 HTRANS  in  2  transfer type; HTRANS[1]=1 (NONSEQ/SEQ) is a valid transfer.
REQ-008 HWRITE  in  1  1=write.
REQ-009 HSIZE  in  3  ignored; all accesses are treated as 32-bit.
REQ-010 HWDATA  in  32  write data, valid in data phase.
REQ-011 HREADY  in  1  bus ready; qualifies the address phase.
REQ-012 HREADYOUT  out  1  constant 1 (zero wait state).
REQ-013 HRESP  out  1  constant 0 (OKAY).
REQ-014 HRDATA  out  32  read data, valid in data phase.
REQ-015 o_tx  out  1  UART serial output, idle high.
REQ-016 o_busy  out  1  high while a frame is shifting or the FIFO is non-empty.

Function
REQ-017 The address phase SHALL be accepted when HSEL & HREADY & HTRANS[1]; HADDR[3:2] and HWRITE SHALL then be registered for the following data-phase cycle.
REQ-018 Register map: 0x0 DATA (W: push HWDATA[7:0]; R: 0); 0x4 STATUS (R: bit0 busy, bit1 full, bit2 empty, bit3 overflow; W: writing 1 to bit3 clears overflow); 0x8 BAUDDIV (R/W, bits[15:0]); 0xC reserved (R: 0, W: ignored).
REQ-019 HRDATA SHALL be driven combinationally from the registered data-phase address and current state; unused bits SHALL be 0.
REQ-020 A DATA write SHALL push HWDATA[7:0] into the FIFO at the end of its data-phase cycle.
REQ-021 A push SHALL be accepted when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs in the same cycle.
REQ-022 A push to a full FIFO without a simultaneous pop SHALL be dropped and SHALL set the sticky overflow flag; overflow set and clear in the same cycle SHALL leave it set.
REQ-023 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.
REQ-024 The TX FSM states SHALL be IDLE, START, DATA, and STOP.
REQ-025 In IDLE, o_tx SHALL be 1; when the FIFO is non-empty, the FSM SHALL pop one byte into the shift register and enter START.
REQ-026 START SHALL drive o_tx = 0 for BAUDDIV clocks, then enter DATA.
REQ-027 DATA SHALL drive the 8 bits LSB first, each for BAUDDIV clocks, then enter STOP.
REQ-028 STOP SHALL drive o_tx = 1 for BAUDDIV clocks, then enter START directly if the FIFO is non-empty (back-to-back, with a pop on that cycle), else enter IDLE.
REQ-029 o_tx SHALL be a registered output.
REQ-030 The first start bit SHALL appear on o_tx 2 cycles after the DATA write data-phase cycle (D), i.e. from cycle D+2, when the FSM was IDLE.
REQ-031 A BAUDDIV value of 0 SHALL be treated as 1.
REQ-032 A BAUDDIV write SHALL take effect at the next bit-counter reload; the current bit SHALL NOT be stretched or truncated.
REQ-033 The bit counter SHALL be 16 bits wide and count down from BAUDDIV-1 to 0.
REQ-034 o_busy SHALL be 1 when state != IDLE or count != 0.

Reset
REQ-035 Reset SHALL force asynchronously: o_tx=1, o_busy=0, state IDLE, FIFO empty (pointers and count 0), overflow 0, BAUDDIV=BAUD_RESET, registered data-phase controls cleared (no pending write).
REQ-036 Assertion of reset mid-frame SHALL abort the frame, discard FIFO contents, and return o_tx to 1 immediately.
REQ-037 After reset release, the first valid transfer SHALL be accepted on the next rising edge.

Verification
REQ-038 Reset, BAUDDIV=4, write DATA=0x55 -> o_tx low from D+2 for 4 clks, bits 1,0,1,0,1,0,1,0 at 4 clks each, high 4 clks, then o_busy=0 after 40 clks total.
REQ-039 BAUDDIV=2, push 0xA5, 0x0F, 0xFF, 0x00 back-to-back -> four contiguous 20-clk frames with no idle gap between STOP and the next START; STATUS reads empty=1 afterwards.
REQ-040 FIFO_DEPTH=4, BAUDDIV=100, push 6 bytes in consecutive cycles -> first byte popped, 4 queued, 6th dropped; STATUS=0xB (busy, full, overflow); write 0x8 to STATUS -> overflow reads 0.
REQ-041 BAUDDIV=8, mid-DATA write BAUDDIV=3 -> current bit lasts 8 clks, subsequent bits last 3 clks.
REQ-042 Assert i_reset during bit 3 of a frame with 2 bytes queued -> o_tx=1 asynchronously, STATUS reads 0x4 and BAUDDIV reads 16 after release; no further frames emitted.
REQ-043 BAUDDIV=0 and read of 0xC -> frame at 1 clk per bit (10 clks), 0xC read returns 0, HREADYOUT=1 and HRESP=0 throughout.
